// File: rtl/data_mem_if.sv
// MEM-stage data-memory request/response bundle between the core (master)
// and a memory responder (slave).
interface data_mem_if;
    logic        mem_req;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [2:0]  mem_req_type;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_error;

    modport master (
        output mem_req, mem_req_write, mem_req_type, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
    );

    modport slave (
        input  mem_req, mem_req_write, mem_req_type, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// word RAM with byte/half/word lanes, extension and error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_error_q, resp_error_d;
    logic             hold_write_q, hold_write_d;
    logic [2:0]       hold_type_q, hold_type_d;
    logic [31:0]      hold_addr_q, hold_addr_d;
    logic [31:0]      hold_wdata_q, hold_wdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             cur_write;
    logic [2:0]       cur_type;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic             misaligned;
    logic             illegal_type;
    logic             req_err;
    logic [4:0]       lane_shift;
    logic [3:0]       byte_en;
    logic [31:0]      st_data;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_data;
    logic             ram_we;

    assign accept = bus.mem_req && ready_q;

    // With LATENCY==1 the access happens on the accept edge itself, before the
    // holding registers are loaded, so the live request is used in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        cur_write = hold_write_q;
        cur_type  = hold_type_q;
        cur_addr  = hold_addr_q;
        cur_wdata = hold_wdata_q;
        if (state_q == S_IDLE) begin
            cur_write = bus.mem_req_write;
            cur_type  = bus.mem_req_type;
            cur_addr  = bus.mem_req_addr;
            cur_wdata = bus.mem_req_wdata;
        end
    end

    // Request decode: word index, range/alignment/type legality and lane steering.
    always_comb begin
        offset       = cur_addr - BASE_ADDR;
        word_idx     = offset[IDX_W+1:2];
        out_of_range = (cur_addr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));
        misaligned   = 1'b0;
        illegal_type = 1'b0;
        case (cur_type)
            F3_B:  illegal_type = 1'b0;
            F3_BU: illegal_type = cur_write;
            F3_H:  misaligned   = cur_addr[0];
            F3_HU: begin
                illegal_type = cur_write;
                misaligned   = cur_addr[0];
            end
            F3_W:  misaligned   = |cur_addr[1:0];
            default: illegal_type = 1'b1;
        endcase
        req_err    = out_of_range || misaligned || illegal_type;
        lane_shift = {cur_addr[1:0], 3'b000};

        case (cur_type[1:0])
            2'b00:   byte_en = 4'b0001 << cur_addr[1:0];
            2'b01:   byte_en = 4'b0011 << {cur_addr[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
        st_data = cur_wdata << lane_shift;

        rd_shift = mem[word_idx] >> lane_shift;
        case (cur_type)
            F3_B:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   ld_data = {24'h0, rd_shift[7:0]};
            F3_HU:   ld_data = {16'h0, rd_shift[15:0]};
            F3_W:    ld_data = rd_shift;
            default: ld_data = 32'h0;
        endcase
    end

    assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == '0));
    assign ram_we     = enter_resp && cur_write && !req_err && !rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'h0;
        resp_error_d = 1'b0;
        hold_write_d = hold_write_q;
        hold_type_d  = hold_type_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_write_d = bus.mem_req_write;
                    hold_type_d  = bus.mem_req_type;
                    hold_addr_d  = bus.mem_req_addr;
                    hold_wdata_d = bus.mem_req_wdata;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_error_d = req_err;
            resp_data_d  = (cur_write || req_err) ? 32'h0 : ld_data;
        end

        ready_d = (state_d == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_error_q <= 1'b0;
            hold_write_q <= 1'b0;
            hold_type_q  <= 3'b000;
            hold_addr_q  <= 32'h0;
            hold_wdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            hold_write_q <= hold_write_d;
            hold_type_q  <= hold_type_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) mem[word_idx][8*lane +: 8] <= st_data[8*lane +: 8];
            end
        end
    end

    assign bus.mem_req_ready  = ready_q;
    assign bus.mem_resp_valid = resp_valid_q;
    assign bus.mem_resp_data  = resp_data_q;
    assign bus.mem_resp_error = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance A (LATENCY=2) covers the data path and errors,
// instance B (LATENCY=4) covers latency scaling and reset during WAIT.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        tb_req = 1'b0;
    logic        tb_write = 1'b0;
    logic [2:0]  tb_type = 3'b010;
    logic [31:0] tb_addr = 32'h0;
    logic [31:0] tb_wdata = 32'h0;

    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_data;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    data_mem_if bus_a ();
    data_mem_if bus_b ();

    assign bus_a.mem_req       = tb_req && !sel;
    assign bus_a.mem_req_write = tb_write;
    assign bus_a.mem_req_type  = tb_type;
    assign bus_a.mem_req_addr  = tb_addr;
    assign bus_a.mem_req_wdata = tb_wdata;
    assign bus_b.mem_req       = tb_req && sel;
    assign bus_b.mem_req_write = tb_write;
    assign bus_b.mem_req_type  = tb_type;
    assign bus_b.mem_req_addr  = tb_addr;
    assign bus_b.mem_req_wdata = tb_wdata;

    assign obs_ready = sel ? bus_b.mem_req_ready  : bus_a.mem_req_ready;
    assign obs_valid = sel ? bus_b.mem_resp_valid : bus_a.mem_resp_valid;
    assign obs_data  = sel ? bus_b.mem_resp_data  : bus_a.mem_resp_data;
    assign obs_err   = sel ? bus_b.mem_resp_error : bus_a.mem_resp_error;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Issues one request on the selected instance and observes it to completion.
    // lat counts edges from the accept edge (inclusive) to the edge raising valid.
    task automatic run_req(input logic wr, input logic [2:0] ty, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] d, output logic e,
                           output int lat, output int rlow, output int vcnt, output bit got);
        int n;
        got = 0; d = 32'h0; e = 1'b0; lat = 0; rlow = 0; vcnt = 0;
        @(negedge clk);
        tb_write = wr; tb_type = ty; tb_addr = addr; tb_wdata = wdata; tb_req = 1'b1;
        n = 0;
        while (!obs_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!obs_ready) begin
            tb_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        tb_req   = 1'b0;
        tb_write = 1'($urandom);
        tb_type  = 3'($urandom);
        tb_addr  = $urandom;
        tb_wdata = $urandom;
        for (int i = 1; i <= 50; i++) begin
            if (!obs_ready) rlow++;
            if (obs_valid) vcnt++;
            if (obs_valid && !got) begin
                got = 1; d = obs_data; e = obs_err; lat = i;
            end
            if (got && obs_ready) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        tb_req = 1'b1; tb_write = 1'b0; tb_type = 3'b010; tb_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: ready=%b valid=%b, want 0/0", i, obs_ready, obs_valid);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1/0", obs_ready, obs_valid);
        end
        @(posedge clk); #1;
        tb_req = 1'b0;
        checks++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_accept: ready=%b valid=%b, want 0/0", obs_ready, obs_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_valid !== 1'b1 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_resp: valid=%b err=%b, want 1/0", obs_valid, obs_err);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_done: valid=%b ready=%b, want 0/1", obs_valid, obs_ready);
        end
    endtask

    task automatic test_word();
        vec_t v[2];
        exp_t ex;
        logic [31:0] d; logic e; int lat, rlow, vc; bit got;
        sel = 1'b0;
        v = '{'{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0},
              '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0}};
        foreach (v[i]) begin
            sb.push_back('{v[i].exp_data, v[i].exp_err});
            run_req(v[i].wr, v[i].ty, v[i].addr, v[i].wdata, d, e, lat, rlow, vc, got);
            ex = sb.pop_front();
            checks++;
            if (!got || d !== ex.data || e !== ex.err) begin
                errors++;
                $display("FAIL word[%0d]: got=%0b data=%h err=%b, want data=%h err=%b", i, got, d, e, ex.data, ex.err);
            end
            checks++;
            if (lat != 2 || rlow != 2 || vc != 1) begin
                errors++;
                $display("FAIL word_timing[%0d]: lat=%0d ready_low=%0d pulses=%0d, want 2/2/1", i, lat, rlow, vc);
            end
        end
    endtask

    task automatic test_byte();
        vec_t v[6];
        exp_t ex;
        logic [31:0] d; logic e; int lat, rlow, vc; bit got;
        sel = 1'b0;
        v = '{'{1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0,        1'b0},
              '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0},
              '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0},
              '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0},
              '{1'b1, 3'b000, 32'h10, 32'hFFFFFF7F, 32'h0,        1'b0},
              '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBE7F, 1'b0}};
        foreach (v[i]) begin
            sb.push_back('{v[i].exp_data, v[i].exp_err});
            run_req(v[i].wr, v[i].ty, v[i].addr, v[i].wdata, d, e, lat, rlow, vc, got);
            ex = sb.pop_front();
            checks++;
            if (!got || d !== ex.data || e !== ex.err) begin
                errors++;
                $display("FAIL byte[%0d]: got=%0b data=%h err=%b, want data=%h err=%b", i, got, d, e, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_half_align();
        vec_t v[9];
        exp_t ex;
        logic [31:0] d; logic e; int lat, rlow, vc; bit got;
        sel = 1'b0;
        v = '{'{1'b1, 3'b001, 32'h16, 32'h00001234, 32'h0,        1'b0},
              '{1'b0, 3'b001, 32'h16, 32'h0,        32'h00001234, 1'b0},
              '{1'b1, 3'b001, 32'h14, 32'hFFFF8001, 32'h0,        1'b0},
              '{1'b0, 3'b001, 32'h14, 32'h0,        32'hFFFF8001, 1'b0},
              '{1'b0, 3'b101, 32'h14, 32'h0,        32'h00008001, 1'b0},
              '{1'b0, 3'b010, 32'h14, 32'h0,        32'h12348001, 1'b0},
              '{1'b0, 3'b001, 32'h15, 32'h0,        32'h0,        1'b1},
              '{1'b1, 3'b010, 32'h12, 32'h11111111, 32'h0,        1'b1},
              '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBE7F, 1'b0}};
        foreach (v[i]) begin
            sb.push_back('{v[i].exp_data, v[i].exp_err});
            run_req(v[i].wr, v[i].ty, v[i].addr, v[i].wdata, d, e, lat, rlow, vc, got);
            ex = sb.pop_front();
            checks++;
            if (!got || d !== ex.data || e !== ex.err) begin
                errors++;
                $display("FAIL half[%0d]: got=%0b data=%h err=%b, want data=%h err=%b", i, got, d, e, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_range_type();
        vec_t v[10];
        exp_t ex;
        logic [31:0] d; logic e; int lat, rlow, vc; bit got;
        sel = 1'b0;
        v = '{'{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1},
              '{1'b1, 3'b010, 32'h1000, 32'h12345678, 32'h0,        1'b1},
              '{1'b1, 3'b100, 32'h10,   32'h00000011, 32'h0,        1'b1},
              '{1'b1, 3'b101, 32'h10,   32'h00002222, 32'h0,        1'b1},
              '{1'b0, 3'b010, 32'h10,   32'h0,        32'h80ADBE7F, 1'b0},
              '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1},
              '{1'b0, 3'b010, 32'h11,   32'h0,        32'h0,        1'b1},
              '{1'b1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0},
              '{1'b0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0},
              '{1'b0, 3'b100, 32'hFFF,  32'h0,        32'h000000CA, 1'b0}};
        foreach (v[i]) begin
            sb.push_back('{v[i].exp_data, v[i].exp_err});
            run_req(v[i].wr, v[i].ty, v[i].addr, v[i].wdata, d, e, lat, rlow, vc, got);
            ex = sb.pop_front();
            checks++;
            if (!got || d !== ex.data || e !== ex.err) begin
                errors++;
                $display("FAIL range[%0d]: got=%0b data=%h err=%b, want data=%h err=%b", i, got, d, e, ex.data, ex.err);
            end
        end
    endtask

    // Request held high through WAIT/RESP must not be taken as a second request.
    task automatic test_not_ready();
        exp_t ex;
        int pulses;
        sel = 1'b0;
        sb.push_back('{32'h80ADBE7F, 1'b0});
        @(negedge clk);
        tb_write = 1'b0; tb_type = 3'b010; tb_addr = 32'h10; tb_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tb_req = 1'b0;
        ex = sb.pop_front();
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== ex.data || obs_err !== ex.err) begin
            errors++;
            $display("FAIL held_req_resp: valid=%b data=%h err=%b, want 1 data=%h err=%b",
                     obs_valid, obs_data, obs_err, ex.data, ex.err);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (obs_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL held_req_ignored: extra pulses=%0d, want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_op();
        vec_t v[2];
        exp_t ex;
        logic [31:0] d; logic e; int lat, rlow, vc; bit got;
        int pulses;
        sel = 1'b1;
        v = '{'{1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0},
              '{1'b0, 3'b010, 32'h20, 32'h0,        32'h0, 1'b0}};
        foreach (v[i]) begin
            sb.push_back('{v[i].exp_data, v[i].exp_err});
            run_req(v[i].wr, v[i].ty, v[i].addr, v[i].wdata, d, e, lat, rlow, vc, got);
            ex = sb.pop_front();
            checks++;
            if (!got || d !== ex.data || e !== ex.err || lat != 4 || rlow != 4) begin
                errors++;
                $display("FAIL lat4[%0d]: got=%0b data=%h err=%b lat=%0d ready_low=%0d, want data=%h err=%b lat=4 ready_low=4",
                         i, got, d, e, lat, rlow, ex.data, ex.err);
            end
        end

        @(negedge clk);
        tb_write = 1'b1; tb_type = 3'b010; tb_addr = 32'h20; tb_wdata = 32'h55; tb_req = 1'b1;
        @(posedge clk); #1;
        tb_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_now: valid=%b ready=%b, want 0/0", obs_valid, obs_ready);
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (obs_valid) pulses++;
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (obs_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: pulses=%0d ready=%b, want 0/1", pulses, obs_ready);
        end

        sb.push_back('{32'h0, 1'b0});
        run_req(1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, rlow, vc, got);
        ex = sb.pop_front();
        checks++;
        if (!got || d !== ex.data || e !== ex.err) begin
            errors++;
            $display("FAIL abort_ram_kept: got=%0b data=%h err=%b, want data=%h err=%b", got, d, e, ex.data, ex.err);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_align();
        test_range_type();
        test_not_ready();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
